pio_loader: RTL and testbench

- Sequencer that owns the PIO host action bus (action/index/mindex/din).
- On `start`, it reads a program from an external instruction memory and writes each instruction into the PIO.
- It then issues the per-machine configuration (wrap end, divider, pin groups, side-set, shift) and enables the machine.
- After that it streams host words into the machine's TX FIFO through a valid/ready handshake, throttled by the PIO `full` flags.

---
 rtl/pio_loader.sv | 153 +++++++++++++++
 tb/tb_pio_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pio_loader.sv
// PIO loader: writes a program from instruction memory into the PIO, configures one machine,
// then streams host words into its TX FIFO. Optional PUSH pacing under PIO_LOADER_PACE_EN.
module pio_loader #(
  parameter int PACE_CYCLES = 180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        cfg_done,
  input  logic [5:0]  cfg_plen,
  input  logic [1:0]  cfg_mindex,
  input  logic [23:0] cfg_div,
  input  logic [31:0] cfg_grps,
  input  logic [4:0]  cfg_sides,
  input  logic [31:0] cfg_shift,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [3:0]  pio_action,
  output logic [4:0]  pio_index,
  output logic [1:0]  pio_mindex,
  output logic [31:0] pio_din,
  input  logic [3:0]  pio_full
);
  localparam logic [3:0] A_NONE = 4'd0, A_INSTR = 4'd1, A_PEND = 4'd2, A_PUSH = 4'd4,
                         A_GRPS = 4'd5, A_EN = 4'd6, A_DIV = 4'd7, A_SIDES = 4'd8,
                         A_SHIFT = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE, S_PREF, S_INSTR, S_PEND, S_DIV, S_GRPS, S_SIDES, S_SHIFT, S_EN, S_STREAM, S_DIS
  } state_t;

  state_t      state, state_n;
  logic [1:0]  mind, mind_n;
  logic [5:0]  plen, plen_n, plen_c, idx, idx_n, addr6;
  logic [3:0]  act_n;
  logic [4:0]  index_n, addr_n;
  logic [31:0] din_n;
  logic        hs, push_last, pace_ok;

  if (PACE_CYCLES < 1) begin : g_bad_pace
    $error("PACE_CYCLES must be at least 1");
  end

  assign plen_c    = (cfg_plen > 6'd32) ? 6'd32 : cfg_plen;
  assign push_last = (pio_action == A_PUSH);
  assign busy      = (state != S_IDLE);
  assign cfg_done  = (state == S_STREAM);
  assign tx_ready  = (state == S_STREAM) && !pio_full[mind] && !push_last && pace_ok;
  assign hs        = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      mind       <= '0;
      plen       <= '0;
      idx        <= '0;
      pio_action <= A_NONE;
      pio_index  <= '0;
      pio_mindex <= '0;
      pio_din    <= '0;
      prog_addr  <= '0;
    end else begin
      state      <= state_n;
      mind       <= mind_n;
      plen       <= plen_n;
      idx        <= idx_n;
      pio_action <= act_n;
      pio_index  <= index_n;
      pio_mindex <= (act_n != A_NONE) ? mind_n : 2'd0;
      pio_din    <= din_n;
      prog_addr  <= addr_n;
    end
  end

  // state register holds the phase whose action is currently on the bus
  always_comb begin
    state_n = state;
    idx_n   = idx;
    mind_n  = mind;
    plen_n  = plen;
    case (state)
      S_IDLE: if (start) begin
        mind_n  = cfg_mindex;
        plen_n  = plen_c;
        state_n = (plen_c != 6'd0) ? S_PREF : S_PEND;
      end
      S_PREF:  begin state_n = S_INSTR; idx_n = 6'd0; end
      S_INSTR: if (idx == plen - 6'd1) state_n = S_PEND;
               else idx_n = idx + 6'd1;
      S_PEND:   state_n = S_DIV;
      S_DIV:    state_n = S_GRPS;
      S_GRPS:   state_n = S_SIDES;
      S_SIDES:  state_n = S_SHIFT;
      S_SHIFT:  state_n = S_EN;
      S_EN:     state_n = S_STREAM;
      S_STREAM: state_n = S_STREAM;
      S_DIS:    state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (stop && state != S_IDLE && state != S_DIS) state_n = S_DIS;
  end

  // next registered bus values, derived from the state being entered
  always_comb begin
    act_n   = A_NONE;
    index_n = '0;
    din_n   = '0;
    addr_n  = '0;
    addr6   = idx_n + 6'd2;
    case (state_n)
      S_PREF:  addr_n = 5'd1;
      S_INSTR: begin
        act_n   = A_INSTR;
        index_n = idx_n[4:0];
        din_n   = {16'h0, prog_data};
        addr_n  = (addr6 > 6'd31) ? 5'd31 : addr6[4:0];
      end
      S_PEND:  begin
        act_n = A_PEND;
        din_n = (plen_n == 6'd0) ? 32'd0 : {26'd0, plen_n - 6'd1};
      end
      S_DIV:   begin act_n = A_DIV;   din_n = {8'h0, cfg_div}; end
      S_GRPS:  begin act_n = A_GRPS;  din_n = cfg_grps; end
      S_SIDES: begin act_n = A_SIDES; din_n = {27'h0, cfg_sides}; end
      S_SHIFT: begin act_n = A_SHIFT; din_n = cfg_shift; end
      S_EN:    begin act_n = A_EN;    din_n = 32'h1 << mind_n; end
      S_STREAM: if (state == S_STREAM && hs) begin
        act_n = A_PUSH;
        din_n = tx_data;
      end
      S_DIS:   act_n = A_EN;
      default: act_n = A_NONE;
    endcase
  end

`ifdef PIO_LOADER_PACE_EN
  localparam int PW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
  logic [PW-1:0] pace_cnt;
  always_ff @(posedge clk) begin
    if (!reset || stop)          pace_cnt <= '0;
    else if (act_n == A_PUSH)    pace_cnt <= PW'(PACE_CYCLES - 1);
    else if (pace_cnt != '0)     pace_cnt <= pace_cnt - 1'b1;
  end
  assign pace_ok = (pace_cnt == '0);
`else
  assign pace_ok = 1'b1;
`endif
endmodule

// File: tb/tb_pio_loader.sv
// Scoreboard bench for pio_loader: stimulus queues expected bus actions with cycle stamps,
// a negedge monitor pops and compares every non-NONE action.
module tb_pio_loader;
`ifdef PIO_LOADER_PACE_EN
  localparam int GAP = 180;
`else
  localparam int GAP = 2;
`endif

  logic        clk = 0, reset = 0, start = 0, stop = 0;
  logic        busy, cfg_done, tx_ready, tx_valid = 0;
  logic [5:0]  cfg_plen = 0;
  logic [1:0]  cfg_mindex = 0, pio_mindex;
  logic [23:0] cfg_div = 0;
  logic [31:0] cfg_grps = 0, cfg_shift = 0, tx_data = 0, pio_din;
  logic [4:0]  cfg_sides = 0, prog_addr, pio_index;
  logic [15:0] prog_data = 0;
  logic [3:0]  pio_action, pio_full = 0;

  typedef struct {
    logic [3:0]  act;
    logic [4:0]  idx;
    logic [1:0]  mi;
    logic [31:0] din;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic [15:0] mem [32];
  int cyc = 0, total = 0, bad = 0;

  pio_loader dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .busy(busy), .cfg_done(cfg_done),
    .cfg_plen(cfg_plen), .cfg_mindex(cfg_mindex), .cfg_div(cfg_div), .cfg_grps(cfg_grps),
    .cfg_sides(cfg_sides), .cfg_shift(cfg_shift), .prog_addr(prog_addr), .prog_data(prog_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .pio_action(pio_action),
    .pio_index(pio_index), .pio_mindex(pio_mindex), .pio_din(pio_din), .pio_full(pio_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) prog_data <= mem[prog_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // monitor
  always @(negedge clk) begin
    if (pio_action != 4'd0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_action cyc=%0d act=%0d idx=%0d mi=%0d din=%h", cyc,
                 pio_action, pio_index, pio_mindex, pio_din);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (pio_action !== e.act || pio_index !== e.idx || pio_mindex !== e.mi ||
            pio_din !== e.din || cyc != e.cyc) begin
          bad++;
          $display("FAIL sb_action got cyc=%0d act=%0d idx=%0d mi=%0d din=%h exp cyc=%0d act=%0d idx=%0d mi=%0d din=%h",
                   cyc, pio_action, pio_index, pio_mindex, pio_din,
                   e.cyc, e.act, e.idx, e.mi, e.din);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, expv);
    end
  endtask

  task automatic expect_act(input logic [3:0] a, input int i, input logic [1:0] m,
                            input logic [31:0] d, input int c);
    exp_t e;
    e.act = a; e.idx = 5'(i); e.mi = m; e.din = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    check({name, "_action"}, {28'd0, pio_action}, 0);
    check({name, "_din"}, pio_din, 0);
    check({name, "_idx_mi_addr"}, {20'd0, pio_index, pio_mindex, prog_addr}, 0);
    check({name, "_flags"}, {29'd0, busy, cfg_done, tx_ready}, 0);
  endtask

  // n is the hand-clamped program length
  task automatic load(input logic [5:0] plen, input logic [1:0] mi, input int n);
    int s, b;
    step();
    cfg_plen = plen; cfg_mindex = mi; start = 1; s = cyc;
    for (int k = 0; k < n; k++) expect_act(4'd1, k, mi, {16'h0, mem[k]}, s + 2 + k);
    b = (n > 0) ? s + 2 + n : s + 1;
    expect_act(4'd2, 0, mi, (n > 0) ? 32'(n - 1) : 32'd0, b);
    expect_act(4'd7, 0, mi, {8'h0, cfg_div}, b + 1);
    expect_act(4'd5, 0, mi, cfg_grps, b + 2);
    expect_act(4'd8, 0, mi, {27'h0, cfg_sides}, b + 3);
    expect_act(4'd10, 0, mi, cfg_shift, b + 4);
    expect_act(4'd6, 0, mi, 32'h1 << mi, b + 5);
    step();
    start = 0;
    wait_cyc(b + 5);
    @(negedge clk);
    check("cfg_done_before", {31'd0, cfg_done}, 0);
    step();
    @(negedge clk);
    check("cfg_done_rise", {30'd0, cfg_done, busy}, 32'h3);
  endtask

  task automatic do_stop(input logic [1:0] mi, input bit with_hs);
    int s;
    step();
    stop = 1; s = cyc;
    if (with_hs) begin tx_valid = 1; tx_data = 32'h77; end
    expect_act(4'd6, 0, mi, 32'd0, s + 1);
    @(negedge clk);
    if (with_hs) check("stop_hs_ready", {31'd0, tx_ready}, 1);
    step();
    stop = 0; tx_valid = 0;
    @(negedge clk);
    check("stop_busy_en", {31'd0, busy}, 1);
    step();
    @(negedge clk);
    check("stop_busy_idle", {31'd0, busy}, 0);
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    bit ok = 0;
    tx_data = d; tx_valid = 1;
    while (!ok && n < 400) begin
      @(negedge clk);
      if (tx_ready) ok = 1;
      step();
      n++;
    end
    tx_valid = 0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  initial begin
    int c, f;
    mem = '{default: 16'h0};
    mem[0] = 16'hE081; mem[1] = 16'h6001; mem[2] = 16'h0000; mem[3] = 16'h1800;
    repeat (3) step();
    check_idle_outputs("reset");
    step();
    reset = 1;

    // program of 4, machine 0
    cfg_div = 24'h000200; cfg_grps = 32'h40100000; cfg_sides = 5'd1; cfg_shift = 32'h00080000;
    load(6'd4, 2'd0, 4);

    // stream ten words, full clear
    step();
    c = cyc;
    for (int i = 0; i < 10; i++) expect_act(4'd4, 0, 2'd0, 32'h30 + i, c + 1 + GAP * i);
    for (int i = 0; i < 10; i++) send(32'h30 + i);
    @(negedge clk);
    check("ready_after_push", {31'd0, tx_ready}, 0);
    repeat (200) step();

    // full backpressure for 5 cycles
    pio_full = 4'b0001; tx_valid = 1; tx_data = 32'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_blocks_ready", {31'd0, tx_ready}, 0);
      step();
    end
    pio_full = 4'b0000; f = cyc;
    expect_act(4'd4, 0, 2'd0, 32'h55, f + 1);
    @(negedge clk);
    check("ready_after_full", {31'd0, tx_ready}, 1);
    step();
    tx_valid = 0;
    repeat (200) step();

    // stop coincident with handshake
    do_stop(2'd0, 1);
    repeat (3) step();
    check("sb_drained_1", sb.size(), 0);

    // empty program, machine 2
    cfg_div = 24'h123456; cfg_grps = 32'hDEADBEEF; cfg_sides = 5'h1F; cfg_shift = 32'h12345678;
    load(6'd0, 2'd2, 0);
    do_stop(2'd2, 0);

    // reset while INSTR k=2 is on the bus
    step();
    cfg_plen = 6'd4; cfg_mindex = 2'd1; start = 1; c = cyc;
    for (int k = 0; k < 3; k++) expect_act(4'd1, k, 2'd1, {16'h0, mem[k]}, c + 2 + k);
    step();
    start = 0;
    wait_cyc(c + 4);
    reset = 0;
    step();
    reset = 1;
    check_idle_outputs("midreset");
    check("sb_drained_2", sb.size(), 0);
    load(6'd4, 2'd1, 4);
    do_stop(2'd1, 0);

    // oversize length clamps to 32
    for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
    load(6'd40, 2'd3, 32);
    do_stop(2'd3, 0);

    repeat (5) step();
    check("sb_drained_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
